chan_cfg_sequencer: RTL and testbench
=====================================

# chan_cfg_sequencer

Sequences the per-channel configuration decoded from a control frame into the channel datapaths. On a validated configuration pulse from the Ethernet packet parser, it snapshots the general and per-channel fields. It then programs each active channel in ascending order over a shared config bus with a per-channel req/ack handshake, using an ack timeout and fft-size validation. It sits between the packet parser and the four channel threshold/FFT/tuning datapaths.

## Interface
- NUM_CH, 4: number of channel datapaths (1..8)
- ACK_TIMEOUT, 255: cycles to wait for ack before declaring a channel failed (1..65535)
- FFT_MIN / FFT_MAX, 6 / 12: legal range of log2 FFT size code

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_valid  in  1  one-cycle pulse: parser fields below are complete and stable
- num_channels  in  8  channels to program, starting from channel 0
- ch_threshold  in  NUM_CH*32  channel i at [32i+31:32i]
- ch_mode  in  NUM_CH*8  channel i at [8i+7:8i]
- ch_fft_size  in  NUM_CH*8  log2 FFT size code
- ch_frequency  in  NUM_CH*32  tuning word
- cfg_ack  in  NUM_CH  per-channel accept, may be a level or a pulse
- cfg_req  out  NUM_CH  one-hot (or zero) request
- cfg_threshold / cfg_frequency  out  32  shared bus, valid while any cfg_req bit is high
- cfg_mode / cfg_fft_size  out  8  shared bus
- busy  out  1  high from the cycle after an accepted cfg_valid until the done pulse, inclusive
- done  out  1  one-cycle pulse at the end of a pass
- err_mask  out  NUM_CH  per-channel failure from the last pass (timeout or bad fft size), valid from done
- applied_count  out  4  channels successfully acked in the last pass

## Operation
- Reset values: all outputs 0; state IDLE; pending flag 0; snapshot registers 0.
- States: IDLE, LATCH, CHECK, WAIT_ACK, NEXT, DONE.
- IDLE, cfg_valid=1: go to LATCH. LATCH registers all inputs and sets n = min(num_channels, NUM_CH), i=0, err_mask=0, applied_count=0.
- LATCH: if n=0, go to DONE; else go to CHECK.
- CHECK: if the fft_size of channel i is outside [FFT_MIN, FFT_MAX], set err_mask[i] and go to NEXT with no request. Otherwise drive the bus from the snapshot, set cfg_req[i], clear the timeout counter, and go to WAIT_ACK.
- WAIT_ACK: the bus and cfg_req[i] are held constant.
  - cfg_ack[i]=1: clear cfg_req, increment applied_count, go to NEXT.
  - Counter reaches ACK_TIMEOUT-1 without ack: clear cfg_req, set err_mask[i], go to NEXT.
  - Ack and the final timeout cycle coincide: the ack wins.
  - cfg_ack bits for j≠i are ignored in every state.
- NEXT: i+1; if i+1=n, go to DONE; else go to CHECK.
- DONE: done=1 for one cycle. err_mask and applied_count hold until the next LATCH. Go to IDLE, or to LATCH if the pending flag is set (the flag is cleared there).
- A cfg_valid while busy sets the pending flag. Multiple pulses collapse to one. Inputs are re-sampled at the re-entry to LATCH. The in-flight pass is never aborted.
- The bus outputs return to 0 whenever cfg_req=0.
- rst mid-pass: all outputs 0 at the next edge and the pending flag is cleared. No partial done is issued.

## Timing
- cfg_valid at edge T: LATCH at T+1, CHECK at T+2, cfg_req[0] and bus valid from T+3.
- Ack sampled at edge A: cfg_req low at A+1, NEXT at A+1, CHECK at A+2, next cfg_req at A+3.
- With acks on the first request cycle, channel k's request starts at T+3+3k. done is high 2 cycles after the last NEXT.
- Timeout: cfg_req[i] is high for exactly ACK_TIMEOUT cycles.
- Bad-fft channel: costs 2 cycles (CHECK, NEXT) and no request is issued.
- busy falls in the cycle after done unless the pending flag restarts the sequencer, in which case busy stays high continuously.

## Structure
- Shared package cfg_pkg: the state enum, FFT_MIN/FFT_MAX, and field widths (THRESH_W=32, FREQ_W=32, MODE_W=8). The parser and the channel datapaths also import it.
- One sub-module, cfg_timeout_ctr: a loadable down-counter with clear, load value ACK_TIMEOUT-1, and a zero flag.
- Field slicing of the flattened buses happens in a combinational index mux on i inside the top level.

## Test plan
- num_channels=4, all fft=10, acks returned 2 cycles after each req -> reqs 0,1,2,3 in order, each with the matching snapshot on the bus; done; applied_count=4; err_mask=0.
- Channel 2 never acks, ACK_TIMEOUT=16 -> cfg_req[2] is high for exactly 16 cycles; err_mask=4'b0100; applied_count=3; channel 3 is still programmed.
- ch1 fft=3 and ch3 fft=13 -> no req on channels 1 or 3; err_mask=4'b1010; applied_count=2.
- num_channels=0 -> done at T+3 with no req; num_channels=9 -> exactly 4 channels are programmed.
- Second cfg_valid during channel 1 with changed ch0_threshold=0xDEADBEEF -> first pass completes unchanged, then a second pass starts with no idle gap in busy and drives 0xDEADBEEF to channel 0.
- rst asserted in WAIT_ACK -> cfg_req, busy, and bus are 0 at the next edge; no done; a following cfg_valid starts a clean pass at channel 0.

Source files
------------

// File: rtl/cfg_pkg.sv
// Types and constants shared by the frame parser, the config sequencer and the
// channel datapaths.
package cfg_pkg;

    localparam int unsigned THRESH_W = 32;
    localparam int unsigned FREQ_W   = 32;
    localparam int unsigned MODE_W   = 8;
    localparam int unsigned FFT_W    = 8;

    // Legal range of the log2 FFT size code.
    localparam int unsigned FFT_MIN = 6;
    localparam int unsigned FFT_MAX = 12;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StCheck,
        StWaitAck,
        StNext,
        StDone
    } cfg_state_e;

    function automatic logic fft_in_range(input logic [FFT_W-1:0] code);
        return (32'(code) >= FFT_MIN) && (32'(code) <= FFT_MAX);
    endfunction

endpackage

// File: rtl/cfg_timeout_ctr.sv
// Ack timeout counter: loads LOAD_VAL, counts down to zero and holds there.
module cfg_timeout_ctr #(
    parameter int unsigned LOAD_VAL = 254,
    parameter int unsigned WIDTH    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= WIDTH'(LOAD_VAL);
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/chan_cfg_sequencer.sv
// Snapshots a parsed control frame and programs each active channel in turn
// over a shared config bus with a per-channel req/ack handshake.
module chan_cfg_sequencer
    import cfg_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    input  logic [7:0]                 num_channels,
    input  logic [NUM_CH*THRESH_W-1:0] ch_threshold,
    input  logic [NUM_CH*MODE_W-1:0]   ch_mode,
    input  logic [NUM_CH*FFT_W-1:0]    ch_fft_size,
    input  logic [NUM_CH*FREQ_W-1:0]   ch_frequency,
    input  logic [NUM_CH-1:0]          cfg_ack,
    output logic [NUM_CH-1:0]          cfg_req,
    output logic [THRESH_W-1:0]        cfg_threshold,
    output logic [FREQ_W-1:0]          cfg_frequency,
    output logic [MODE_W-1:0]          cfg_mode,
    output logic [FFT_W-1:0]           cfg_fft_size,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_CH-1:0]          err_mask,
    output logic [3:0]                 applied_count
);

    cfg_state_e state_q, state_d;

    logic                       pending_q, pending_d;
    logic [3:0]                 n_q, n_d;
    logic [3:0]                 idx_q, idx_d;
    logic [3:0]                 applied_q, applied_d;
    logic [NUM_CH-1:0]          err_q, err_d;
    logic [NUM_CH-1:0]          req_q, req_d;
    logic                       done_q, done_d;
    logic                       snap_en;

    logic [NUM_CH*THRESH_W-1:0] thr_q;
    logic [NUM_CH*MODE_W-1:0]   mode_q;
    logic [NUM_CH*FFT_W-1:0]    fft_q;
    logic [NUM_CH*FREQ_W-1:0]   freq_q;

    logic [THRESH_W-1:0]        sel_thr;
    logic [FREQ_W-1:0]          sel_freq;
    logic [MODE_W-1:0]          sel_mode;
    logic [FFT_W-1:0]           sel_fft;
    logic [NUM_CH-1:0]          sel_onehot;
    logic                       sel_ack;

    logic [3:0]                 n_in;
    logic                       ctr_clr, ctr_load, ctr_dec, ctr_zero;
    logic                       req_active;

    assign n_in = (num_channels > 8'(NUM_CH)) ? 4'(NUM_CH) : num_channels[3:0];

    cfg_timeout_ctr #(
        .LOAD_VAL (ACK_TIMEOUT - 1),
        .WIDTH    (16)
    ) u_timeout_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (ctr_clr),
        .load (ctr_load),
        .dec  (ctr_dec),
        .zero (ctr_zero)
    );

    // Field slicing of the snapshot for the channel currently addressed.
    always_comb begin
        sel_thr    = '0;
        sel_freq   = '0;
        sel_mode   = '0;
        sel_fft    = '0;
        sel_onehot = '0;
        sel_ack    = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (idx_q == 4'(c)) begin
                sel_thr       = thr_q[c*THRESH_W +: THRESH_W];
                sel_freq      = freq_q[c*FREQ_W +: FREQ_W];
                sel_mode      = mode_q[c*MODE_W +: MODE_W];
                sel_fft       = fft_q[c*FFT_W +: FFT_W];
                sel_onehot[c] = 1'b1;
                sel_ack       = cfg_ack[c];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        n_d       = n_q;
        idx_d     = idx_q;
        applied_d = applied_q;
        err_d     = err_q;
        req_d     = req_q;
        done_d    = 1'b0;
        snap_en   = 1'b0;
        ctr_clr   = 1'b0;
        ctr_load  = 1'b0;
        ctr_dec   = 1'b0;

        // IDLE and DONE consume cfg_valid directly; elsewhere it is queued.
        if (cfg_valid && (state_q != StIdle) && (state_q != StDone)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                snap_en   = 1'b1;
                pending_d = cfg_valid;
                n_d       = n_in;
                idx_d     = '0;
                err_d     = '0;
                applied_d = '0;
                state_d   = (n_in == '0) ? StDone : StCheck;
            end
            StCheck: begin
                if (!fft_in_range(sel_fft)) begin
                    err_d   = err_q | sel_onehot;
                    state_d = StNext;
                end else begin
                    req_d    = sel_onehot;
                    ctr_load = 1'b1;
                    state_d  = StWaitAck;
                end
            end
            StWaitAck: begin
                ctr_dec = 1'b1;
                if (sel_ack) begin
                    req_d     = '0;
                    applied_d = applied_q + 4'd1;
                    ctr_clr   = 1'b1;
                    state_d   = StNext;
                end else if (ctr_zero) begin
                    req_d   = '0;
                    err_d   = err_q | sel_onehot;
                    ctr_clr = 1'b1;
                    state_d = StNext;
                end
            end
            StNext: begin
                idx_d   = idx_q + 4'd1;
                state_d = ((idx_q + 4'd1) == n_q) ? StDone : StCheck;
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = (pending_q || cfg_valid) ? StLatch : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            n_q       <= '0;
            idx_q     <= '0;
            applied_q <= '0;
            err_q     <= '0;
            req_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            applied_q <= applied_d;
            err_q     <= err_d;
            req_q     <= req_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            thr_q  <= '0;
            mode_q <= '0;
            fft_q  <= '0;
            freq_q <= '0;
        end else if (snap_en) begin
            thr_q  <= ch_threshold;
            mode_q <= ch_mode;
            fft_q  <= ch_fft_size;
            freq_q <= ch_frequency;
        end
    end

    assign req_active    = |req_q;
    assign cfg_req       = req_q;
    assign cfg_threshold = req_active ? sel_thr  : '0;
    assign cfg_frequency = req_active ? sel_freq : '0;
    assign cfg_mode      = req_active ? sel_mode : '0;
    assign cfg_fft_size  = req_active ? sel_fft  : '0;
    assign busy          = (state_q != StIdle) || done_q;
    assign done          = done_q;
    assign err_mask      = err_q;
    assign applied_count = applied_q;

endmodule

// File: tb/tb_chan_cfg_sequencer.sv
// Directed, table-driven bench for chan_cfg_sequencer with a cycle-level ack
// responder and request logger.
module tb_chan_cfg_sequencer;

    localparam int NCH = 4;
    localparam int TO  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic [7:0]    num_channels = '0;
    logic [127:0]  ch_threshold = '0;
    logic [31:0]   ch_mode = '0;
    logic [31:0]   ch_fft_size = '0;
    logic [127:0]  ch_frequency = '0;
    logic [3:0]    cfg_ack = '0;
    logic [3:0]    cfg_req;
    logic [31:0]   cfg_threshold;
    logic [31:0]   cfg_frequency;
    logic [7:0]    cfg_mode;
    logic [7:0]    cfg_fft_size;
    logic          busy;
    logic          done;
    logic [3:0]    err_mask;
    logic [3:0]    applied_count;

    chan_cfg_sequencer #(
        .NUM_CH      (NCH),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .num_channels  (num_channels),
        .ch_threshold  (ch_threshold),
        .ch_mode       (ch_mode),
        .ch_fft_size   (ch_fft_size),
        .ch_frequency  (ch_frequency),
        .cfg_ack       (cfg_ack),
        .cfg_req       (cfg_req),
        .cfg_threshold (cfg_threshold),
        .cfg_frequency (cfg_frequency),
        .cfg_mode      (cfg_mode),
        .cfg_fft_size  (cfg_fft_size),
        .busy          (busy),
        .done          (done),
        .err_mask      (err_mask),
        .applied_count (applied_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [31:0] thr;
        logic [31:0] freq;
        logic [7:0]  mode;
        logic [7:0]  fft;
        int          start;
        int          len;
    } req_rec_t;

    typedef struct {
        logic [7:0]  nc;
        logic [31:0] fft;
        int          delay;
        logic [3:0]  nack;
        logic [3:0]  spur;
        logic [3:0]  exp_err;
        logic [3:0]  exp_app;
        logic [3:0]  exp_reqs;
    } vec_t;

    req_rec_t   log_q[$];
    int         cyc = 0;
    int         done_cnt = 0;
    int         bad_onehot = 0;
    int         bus_leak = 0;
    int         bus_unstable = 0;
    int         ack_delay = 2;
    logic [3:0] nack_mask = '0;
    logic [3:0] spur_mask = '0;
    int         n_checks = 0;
    int         n_errors = 0;

    function automatic logic [31:0] thr_of(input int v, input int c);
        return {8'hA0 + 8'(v), 8'(c), 16'h5A5A};
    endfunction

    function automatic logic [31:0] freq_of(input int v, input int c);
        return {8'(v), 8'hF0, 8'(c), 8'h33};
    endfunction

    function automatic logic [7:0] mode_of(input int v, input int c);
        return 8'(v * 16 + c);
    endfunction

    function automatic vec_t mk(input logic [7:0] nc, input logic [31:0] fft, input int delay,
                                input logic [3:0] nack, input logic [3:0] spur,
                                input logic [3:0] e_err, input logic [3:0] e_app,
                                input logic [3:0] e_reqs);
        vec_t r;
        r.nc = nc; r.fft = fft; r.delay = delay; r.nack = nack; r.spur = spur;
        r.exp_err = e_err; r.exp_app = e_app; r.exp_reqs = e_reqs;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_pass(output int t);
        cfg_valid = 1'b1;
        tick();
        t = cyc;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int t_done, output int lows);
        t_done = -1;
        lows = 0;
        for (int k = 0; k < max_cyc; k++) begin
            tick();
            if (!busy) lows++;
            if (done) begin
                t_done = cyc;
                break;
            end
        end
        n_checks++;
        if (t_done < 0) begin
            n_errors++;
            $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
        end
    endtask

    task automatic wait_req(input logic [3:0] want, input int max_cyc);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            tick();
            if (cfg_req == want) begin
                ok = 1'b1;
                break;
            end
        end
        check($sformatf("wait_req_%0h", want), 64'(ok), 64'd1);
    endtask

    task automatic apply_vec(input int v, input vec_t tv);
        num_channels = tv.nc;
        ch_fft_size  = tv.fft;
        for (int c = 0; c < NCH; c++) begin
            ch_threshold[c*32 +: 32] = thr_of(v, c);
            ch_frequency[c*32 +: 32] = freq_of(v, c);
            ch_mode[c*8 +: 8]        = mode_of(v, c);
        end
        ack_delay = tv.delay;
        nack_mask = tv.nack;
        spur_mask = tv.spur;
    endtask

    // Ack responder and request logger; runs 1 time unit after each edge.
    initial begin : monitor
        req_rec_t   r;
        int         age;
        logic [3:0] prev_req;
        age = 0;
        prev_req = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) done_cnt++;
            if (cfg_req != '0) begin
                if ($countones(cfg_req) != 1) bad_onehot++;
                if (cfg_req == prev_req && log_q.size() > 0) begin
                    age++;
                    r = log_q[log_q.size()-1];
                    r.len++;
                    if (cfg_threshold != r.thr || cfg_frequency != r.freq ||
                        cfg_mode != r.mode || cfg_fft_size != r.fft) bus_unstable++;
                    log_q[log_q.size()-1] = r;
                end else begin
                    age = 1;
                    r.ch = 0;
                    for (int c = 0; c < NCH; c++) if (cfg_req[c]) r.ch = c;
                    r.thr = cfg_threshold; r.freq = cfg_frequency;
                    r.mode = cfg_mode; r.fft = cfg_fft_size;
                    r.start = cyc; r.len = 1;
                    log_q.push_back(r);
                end
            end else begin
                age = 0;
                if ({cfg_threshold, cfg_frequency, cfg_mode, cfg_fft_size} != '0) bus_leak++;
            end
            prev_req = cfg_req;
            cfg_ack = ((age >= ack_delay) ? (cfg_req & ~nack_mask) : 4'b0) |
                      (~cfg_req & spur_mask);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t       tbl[10];
        vec_t       tv;
        int         t0, t_done, lows, t1, lows2, dc0;
        logic [3:0] got_reqs;
        int         order_bad, data_bad, len_bad, space_bad, exp_len;

        tbl[0] = mk(8'd4, 32'h0A0A0A0A, 2,  4'h0, 4'h0, 4'h0, 4'd4, 4'hF);
        tbl[1] = mk(8'd4, 32'h0A0A0A0A, 2,  4'h4, 4'h4, 4'h4, 4'd3, 4'hF);
        tbl[2] = mk(8'd4, 32'h0D0A030A, 2,  4'h0, 4'h0, 4'hA, 4'd2, 4'h5);
        tbl[3] = mk(8'd0, 32'h0A0A0A0A, 2,  4'h0, 4'h0, 4'h0, 4'd0, 4'h0);
        tbl[4] = mk(8'd9, 32'h0A0A0A0A, 2,  4'h0, 4'h0, 4'h0, 4'd4, 4'hF);
        tbl[5] = mk(8'd3, 32'h0A060C05, 2,  4'h0, 4'h0, 4'h1, 4'd2, 4'h6);
        tbl[6] = mk(8'd2, 32'h0A0A0A0A, 2,  4'h1, 4'h2, 4'h1, 4'd1, 4'h3);
        tbl[7] = mk(8'd1, 32'h0A0A030A, 2,  4'h0, 4'h0, 4'h0, 4'd1, 4'h1);
        tbl[8] = mk(8'd1, 32'h0A0A0A0A, TO, 4'h0, 4'h0, 4'h0, 4'd1, 4'h1);
        tbl[9] = mk(8'd4, 32'h0A0A0A0A, 1,  4'h0, 4'hA, 4'h0, 4'd4, 4'hF);

        rst = 1'b1;
        repeat (3) tick();
        check("rst_req", 64'(cfg_req), 64'd0);
        check("rst_busy_done", 64'({busy, done}), 64'd0);
        check("rst_err_app", 64'({err_mask, applied_count}), 64'd0);
        check("rst_bus", 64'({cfg_threshold, cfg_frequency} | 64'({cfg_mode, cfg_fft_size})),
              64'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 10; v++) begin
            tv = tbl[v];
            apply_vec(v, tv);
            log_q.delete();
            bad_onehot = 0; bus_leak = 0; bus_unstable = 0;
            start_pass(t0);
            wait_done(600, t_done, lows);
            check($sformatf("v%0d_err_mask", v), 64'(err_mask), 64'(tv.exp_err));
            check($sformatf("v%0d_applied", v), 64'(applied_count), 64'(tv.exp_app));
            check($sformatf("v%0d_busy_gap", v), 64'(lows), 64'd0);
            got_reqs = '0; order_bad = 0; data_bad = 0; len_bad = 0; space_bad = 0;
            foreach (log_q[k]) begin
                got_reqs[log_q[k].ch] = 1'b1;
                if (k > 0 && log_q[k].ch <= log_q[k-1].ch) order_bad++;
                if (log_q[k].thr != thr_of(v, log_q[k].ch) ||
                    log_q[k].freq != freq_of(v, log_q[k].ch) ||
                    log_q[k].mode != mode_of(v, log_q[k].ch) ||
                    log_q[k].fft != tv.fft[log_q[k].ch*8 +: 8]) data_bad++;
                exp_len = tv.nack[log_q[k].ch] ? TO : tv.delay;
                if (log_q[k].len != exp_len) len_bad++;
                if (log_q[k].start != t0 + 2 + 3 * k) space_bad++;
            end
            check($sformatf("v%0d_req_set", v), 64'(got_reqs), 64'(tv.exp_reqs));
            check($sformatf("v%0d_req_count", v), 64'(log_q.size()),
                  64'($countones(tv.exp_reqs)));
            check($sformatf("v%0d_order", v), 64'(order_bad), 64'd0);
            check($sformatf("v%0d_bus_data", v), 64'(data_bad), 64'd0);
            check($sformatf("v%0d_req_len", v), 64'(len_bad), 64'd0);
            check($sformatf("v%0d_bus_hygiene", v),
                  64'(bad_onehot + bus_leak + bus_unstable), 64'd0);
            if (log_q.size() > 0 && tv.exp_reqs[0])
                check($sformatf("v%0d_first_req_time", v), 64'(log_q[0].start), 64'(t0 + 2));
            if (tv.nc == 8'd0)
                check("v3_done_latency", 64'(t_done), 64'(t0 + 2));
            if (tv.delay == 1)
                check($sformatf("v%0d_req_spacing", v), 64'(space_bad), 64'd0);
            tick();
            check($sformatf("v%0d_after_done", v), 64'({done, busy}), 64'd0);
            tick();
            check($sformatf("v%0d_hold", v), 64'({err_mask, applied_count}),
                  64'({tv.exp_err, tv.exp_app}));
        end

        // Re-trigger mid-pass: two pulses collapse into one follow-on pass.
        tv = mk(8'd4, 32'h0A0A0A0A, 2, 4'h0, 4'h0, 4'h0, 4'd4, 4'hF);
        apply_vec(20, tv);
        log_q.delete();
        dc0 = done_cnt;
        start_pass(t0);
        wait_req(4'b0010, 60);
        ch_threshold[31:0] = 32'hDEADBEEF;
        cfg_valid = 1'b1; tick(); cfg_valid = 1'b0; tick();
        cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
        wait_done(600, t_done, lows);
        check("pend_first_count", 64'(log_q.size()), 64'd4);
        check("pend_first_thr0", 64'(log_q[0].thr), 64'(thr_of(20, 0)));
        wait_done(600, t1, lows2);
        check("pend_no_gap", 64'(lows + lows2), 64'd0);
        check("pend_total_reqs", 64'(log_q.size()), 64'd8);
        if (log_q.size() > 4) begin
            check("pend_second_ch", 64'(log_q[4].ch), 64'd0);
            check("pend_second_thr", 64'(log_q[4].thr), 64'h0000_0000_DEAD_BEEF);
        end
        check("pend_second_applied", 64'(applied_count), 64'd4);
        repeat (10) tick();
        check("pend_done_pulses", 64'(done_cnt - dc0), 64'd2);
        check("pend_idle", 64'(busy), 64'd0);

        // Reset while waiting for an ack, with a re-trigger already queued.
        tv = mk(8'd4, 32'h0A0A0A0A, 2, 4'hF, 4'h0, 4'h0, 4'd0, 4'h0);
        apply_vec(21, tv);
        log_q.delete();
        start_pass(t0);
        wait_req(4'b0001, 20);
        repeat (3) tick();
        cfg_valid = 1'b1; tick(); cfg_valid = 1'b0; tick();
        dc0 = done_cnt;
        rst = 1'b1;
        tick();
        check("rst_mid_req", 64'(cfg_req), 64'd0);
        check("rst_mid_busy_done", 64'({busy, done}), 64'd0);
        check("rst_mid_bus", 64'({cfg_threshold, cfg_frequency}), 64'd0);
        rst = 1'b0;
        repeat (30) tick();
        check("rst_mid_no_done", 64'(done_cnt - dc0), 64'd0);
        check("rst_mid_pending_cleared", 64'(busy), 64'd0);
        nack_mask = 4'h0;
        log_q.delete();
        start_pass(t0);
        wait_done(600, t_done, lows);
        check("rst_clean_first_ch", 64'(log_q.size() > 0 ? log_q[0].ch : -1), 64'd0);
        check("rst_clean_first_thr", 64'(log_q.size() > 0 ? log_q[0].thr : 32'd0),
              64'(thr_of(21, 0)));
        check("rst_clean_applied", 64'(applied_count), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
